router_port: RTL

- One router-side port facing a single Node over the byte-serial free/put/payload link.
- Rx path: deserializes 4-byte packets from the Node into 32-bit packets, buffers up to DEPTH of them, and presents them to the router crossbar with a valid/ready handshake.
- Tx path: accepts one 32-bit packet from the crossbar and serializes it to the Node, MSB byte first.
- Packet format: [31:28] src, [27:24] dest, [23:0] data.

---
 rtl/router_port.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/router_port.sv
// Router-side port for one Node: byte-serial Rx deserializer feeding a packet FIFO,
// and a Tx serializer sending one 32-bit packet MSB byte first.
//
// state   | meaning
// RX_IDLE | waiting for the first byte of a packet (free when buffer has room)
// RX_RECV | collecting bytes 2..0 of the current packet
// TX_IDLE | no packet held, tx_ready high
// TX_WAIT | packet latched, waiting for free_from_node
// TX_SEND | driving the four bytes to the Node
module router_port #(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    output logic                       free_to_node,
    input  logic                       put_from_node,
    input  logic [7:0]                 payload_from_node,
    output logic                       pkt_valid,
    output logic [31:0]                pkt_data,
    output logic [3:0]                 pkt_dest,
    input  logic                       pkt_ready,
    output logic [$clog2(DEPTH):0]     rx_count,
    output logic                       rx_overflow,
    input  logic                       tx_valid,
    input  logic [31:0]                tx_pkt,
    output logic                       tx_ready,
    input  logic                       free_from_node,
    output logic                       put_to_node,
    output logic [7:0]                 payload_to_node
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_SEND} tx_state_t;

    rx_state_t       rx_state, rx_next;
    logic [1:0]      rx_idx;
    logic [31:0]     rx_asm;
    logic            rx_drop;
    logic            rx_start, rx_take, rx_push, rx_ovf_hit, rx_pop;
    logic [31:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    tx_state_t       tx_state, tx_next;
    logic [31:0]     tx_buf;
    logic [1:0]      tx_left;
    logic            tx_load, tx_fire, tx_shift, tx_end;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_state <= RX_IDLE;
            tx_state <= TX_IDLE;
        end else begin
            rx_state <= rx_next;
            tx_state <= tx_next;
        end
    end

    always_comb begin
        rx_next    = rx_state;
        rx_start   = 1'b0;
        rx_take    = 1'b0;
        rx_push    = 1'b0;
        rx_ovf_hit = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                // after an overflow, the rest of that burst is dropped until put goes low
                if (put_from_node && !rx_drop) begin
                    if (count != FULL) begin
                        rx_start = 1'b1;
                        rx_next  = RX_RECV;
                    end else begin
                        rx_ovf_hit = 1'b1;
                    end
                end
            end
            RX_RECV: begin
                if (put_from_node) begin
                    rx_take = 1'b1;
                    if (rx_idx == 2'd0) begin
                        rx_push = 1'b1;
                        rx_next = RX_IDLE;
                    end
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    assign rx_pop       = (count != '0) && pkt_ready;
    assign free_to_node = (rx_state == RX_IDLE) && (count != FULL);
    assign pkt_valid    = (count != '0);
    assign pkt_data     = mem[rd_ptr];
    assign pkt_dest     = pkt_data[27:24];
    assign rx_count     = count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_idx      <= 2'd3;
            rx_asm      <= '0;
            rx_drop     <= 1'b0;
            rx_overflow <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            if (!put_from_node)  rx_drop <= 1'b0;
            else if (rx_ovf_hit) rx_drop <= 1'b1;
            if (rx_ovf_hit) rx_overflow <= 1'b1;
            if (rx_start) begin
                rx_asm[31:24] <= payload_from_node;
                rx_idx        <= 2'd2;
            end
            if (rx_take) begin
                rx_asm[{rx_idx, 3'b000} +: 8] <= payload_from_node;
                rx_idx <= (rx_idx == 2'd0) ? 2'd3 : rx_idx - 2'd1;
            end
            if (rx_push) wr_ptr <= wr_ptr + 1'b1;
            if (rx_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (rx_push && !rx_pop)      count <= count + 1'b1;
            else if (!rx_push && rx_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && rx_push) mem[wr_ptr] <= {rx_asm[31:8], payload_from_node};
    end

    always_comb begin
        tx_next  = tx_state;
        tx_load  = 1'b0;
        tx_fire  = 1'b0;
        tx_shift = 1'b0;
        tx_end   = 1'b0;
        case (tx_state)
            TX_IDLE: if (tx_valid) begin
                tx_load = 1'b1;
                tx_next = TX_WAIT;
            end
            TX_WAIT: if (free_from_node) begin
                tx_fire = 1'b1;
                tx_next = TX_SEND;
            end
            TX_SEND: begin
                if (tx_left == 2'd0) begin
                    tx_end  = 1'b1;
                    tx_next = TX_IDLE;
                end else begin
                    tx_shift = 1'b1;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    assign tx_ready = (tx_state == TX_IDLE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tx_buf          <= '0;
            tx_left         <= 2'd0;
            put_to_node     <= 1'b0;
            payload_to_node <= 8'h00;
        end else begin
            if (tx_load) tx_buf <= tx_pkt;
            // tx_left counts bytes still to drive after the one currently on the link
            if (tx_fire) begin
                put_to_node     <= 1'b1;
                payload_to_node <= tx_buf[31:24];
                tx_left         <= 2'd3;
            end
            if (tx_shift) begin
                payload_to_node <= tx_buf[{tx_left - 2'd1, 3'b000} +: 8];
                tx_left         <= tx_left - 2'd1;
            end
            if (tx_end) put_to_node <= 1'b0;
        end
    end
endmodule
